// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide sequencer.
//   - md_op_t    : 3-bit operation code presented with each start pulse
//   - md_state_t : IDLE/BUSY view of the latency counter
//   - latency defaults used by md_ctrl
//   - decode helpers that classify an op as multiply-class or divide-class
// Configuration macro: MD_MADD_EN. When it is defined, MADD/MADDU count as
// multiply-class ops. When it is undefined, those two codes decode to nothing.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_MADDU = 3'd7
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    localparam int MD_MULT_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF  = 10;

`ifdef MD_MADD_EN
    localparam bit MD_MADD_ON = 1'b1;
`else
    localparam bit MD_MADD_ON = 1'b0;
`endif

    // Ops that occupy the unit for MULT_LAT cycles. The accumulate ops only
    // join this class when the accumulate feature is built in.
    function automatic logic is_mul_op(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (MD_MADD_ON && ((op == MD_MADD) || (op == MD_MADDU)));
    endfunction

    // Ops that occupy the unit for DIV_LAT cycles.
    function automatic logic is_div_op(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_if.sv
// md_if: E-stage <-> multiply/divide unit connection.
//   start    : E-stage instruction is an md op (sampled with op/rs_e/rt_e)
//   op       : operation code (md_op_t)
//   rs_e     : forwarded rs operand
//   rt_e     : forwarded rt operand
//   md_use_d : D-stage instruction is md-class
//   busy     : multi-cycle operation in flight
//   stall_md : hold D because the unit is occupied
//   hi, lo   : architectural HI/LO registers
// The master modport is the pipeline side, the slave modport is md_ctrl.
interface md_if;
    import md_pkg::*;

    logic        start;
    md_op_t      op;
    logic [31:0] rs_e;
    logic [31:0] rt_e;
    logic        md_use_d;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_e, rt_e, md_use_d,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start, op, rs_e, rt_e, md_use_d,
        output busy, stall_md, hi, lo
    );

endinterface

// File: rtl/md_arith.sv
// md_arith: purely combinational datapath of the multiply/divide unit.
//   op             : operation code
//   rs, rt         : operands
//   hi, lo         : current HI/LO, used as the accumulator for MADD/MADDU
//   res_hi, res_lo : result to be committed when the op finishes
//   div0           : divisor is zero; a divide must then leave HI/LO alone
// Signed division is done on magnitudes and the signs are re-applied
// afterwards. This keeps the 0x80000000 / -1 corner well defined: the
// quotient wraps to 0x80000000 and the remainder is 0.
module md_arith
    import md_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] mq;
    logic [31:0] mr;
    logic [31:0] sq;
    logic [31:0] sr;

    // Compute every candidate result and pick one by op.
    always_comb begin
        prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        prod_u = {32'd0, rs} * {32'd0, rt};

        div0  = (rt == 32'd0);
        mag_a = rs[31] ? (~rs + 32'd1) : rs;
        mag_b = rt[31] ? (~rt + 32'd1) : rt;

        uq = 32'd0;
        ur = 32'd0;
        mq = 32'd0;
        mr = 32'd0;
        if (!div0) begin
            uq = rs / rt;
            ur = rs % rt;
            mq = mag_a / mag_b;
            mr = mag_a % mag_b;
        end
        // Quotient is negative when the operand signs differ; the remainder
        // follows the dividend.
        sq = (rs[31] ^ rt[31]) ? (~mq + 32'd1) : mq;
        sr = rs[31] ? (~mr + 32'd1) : mr;

        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV:   {res_hi, res_lo} = {sr, sq};
            MD_DIVU:  {res_hi, res_lo} = {ur, uq};
            MD_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
            MD_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
            default:  {res_hi, res_lo} = {hi, lo};
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: sequencer for the E-stage multiply/divide unit.
//   clk   : system clock, all state changes on the rising edge
//   reset : synchronous, active-high; aborts any op in flight
//   bus   : md_if.slave (start/op/rs_e/rt_e/md_use_d in, busy/stall_md/hi/lo out)
// Parameters: MULT_LAT, DIV_LAT (cycles busy, each >= 1).
// Configuration macro: MD_MADD_EN enables MADD/MADDU accumulate ops. The
// macro is resolved in md_pkg (is_mul_op); without it op 6/7 are NOPs.
// The result is computed at start time and parked in res_hi/res_lo. It is
// copied into HI/LO on the edge where the counter goes 1->0, so busy and the
// new HI/LO change together.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_LAT = MD_MULT_LAT_DEF,
    parameter int DIV_LAT  = MD_DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  bus
);

    localparam int LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    md_state_t   state;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [31:0] hi_q, hi_next;
    logic [31:0] lo_q, lo_next;
    logic [31:0] res_hi_q, res_hi_next;
    logic [31:0] res_lo_q, res_lo_next;
    logic        res_wr_q, res_wr_next;

    logic [31:0] arith_hi;
    logic [31:0] arith_lo;
    logic        arith_div0;
    logic        long_start;

    md_arith u_arith (
        .op     (bus.op),
        .rs     (bus.rs_e),
        .rt     (bus.rt_e),
        .hi     (hi_q),
        .lo     (lo_q),
        .res_hi (arith_hi),
        .res_lo (arith_lo),
        .div0   (arith_div0)
    );

    // The FSM has no separate state flop: a non-zero counter means BUSY.
    assign state = (cnt != '0) ? ST_BUSY : ST_IDLE;

    // State register: counter, HI/LO and the pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            res_wr_q <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            hi_q     <= hi_next;
            lo_q     <= lo_next;
            res_hi_q <= res_hi_next;
            res_lo_q <= res_lo_next;
            res_wr_q <= res_wr_next;
        end
    end

    // Next-state logic. Only IDLE accepts a start. A start while BUSY is
    // dropped completely. A divide by zero still runs its full latency, but
    // it clears res_wr so that HI/LO keep their value at completion.
    always_comb begin
        cnt_next    = cnt;
        hi_next     = hi_q;
        lo_next     = lo_q;
        res_hi_next = res_hi_q;
        res_lo_next = res_lo_q;
        res_wr_next = res_wr_q;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_mul_op(bus.op)) begin
                        cnt_next    = CNT_W'(MULT_LAT);
                        res_hi_next = arith_hi;
                        res_lo_next = arith_lo;
                        res_wr_next = 1'b1;
                    end else if (is_div_op(bus.op)) begin
                        cnt_next    = CNT_W'(DIV_LAT);
                        res_hi_next = arith_hi;
                        res_lo_next = arith_lo;
                        res_wr_next = ~arith_div0;
                    end else if (bus.op == MD_MTHI) begin
                        hi_next = bus.rs_e;
                    end else if (bus.op == MD_MTLO) begin
                        lo_next = bus.rs_e;
                    end
                end
            end
            ST_BUSY: begin
                cnt_next = cnt - CNT_W'(1);
                if ((cnt == CNT_W'(1)) && res_wr_q) begin
                    hi_next = res_hi_q;
                    lo_next = res_lo_q;
                end
            end
            default: cnt_next = '0;
        endcase
    end

    // Outputs. The stall is combinational so that an md-class instruction
    // in D already waits in the cycle the long op is starting.
    always_comb begin
        long_start   = bus.start & (is_mul_op(bus.op) | is_div_op(bus.op));
        bus.busy     = (state == ST_BUSY);
        bus.stall_md = bus.md_use_d & ((state == ST_BUSY) | long_start);
        bus.hi       = hi_q;
        bus.lo       = lo_q;
    end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: self-checking bench for md_ctrl (default latencies 5/10).
// Covers a table of directed ops (multiply, divide, move, divide-by-zero,
// accumulate) followed by hand-written sequences: reset state, start while
// busy, stall timing, and reset in the middle of an op.
// Expected values for op 6/7 depend on MD_MADD_EN.
module tb_md_ctrl;
    import md_pkg::*;

    localparam int LAT_BOUND = 20;

    typedef struct {
        string       name;
        md_op_t      op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;
    vec_t vecs[$];

    md_if bus ();

    md_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global safety net in case a loop is ever broken.
    initial begin
        #200us;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(input string name, input md_op_t op,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                input int lat);
        vec_t v;
        v.name   = name;
        v.op     = op;
        v.rs     = rs;
        v.rt     = rt;
        v.exp_hi = exp_hi;
        v.exp_lo = exp_lo;
        v.lat    = lat;
        return v;
    endfunction

    // Drive one cycle of inputs just after the falling edge, then wait a
    // moment so that the combinational outputs settle before checking.
    task automatic applyStimulus(input logic start, input md_op_t op,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic use_d);
        @(negedge clk);
        bus.start    = start;
        bus.op       = op;
        bus.rs_e     = rs;
        bus.rt_e     = rt;
        bus.md_use_d = use_d;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic noteTimeout(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: busy still high after %0d cycles, expected it to fall", name, LAT_BOUND);
    endtask

    // Issue one op with md_use_d held high. Then count busy cycles, checking
    // that HI/LO hold and stall_md stays up, and finally check the result.
    task automatic runVector(input vec_t v);
        logic [31:0] hi0;
        logic [31:0] lo0;
        int          cycles;
        bit          done;
        hi0 = bus.hi;
        lo0 = bus.lo;
        applyStimulus(1'b1, v.op, v.rs, v.rt, 1'b1);
        checkOutput({v.name, " start stall"}, 32'(bus.stall_md), (v.lat != 0) ? 32'd1 : 32'd0);
        checkOutput({v.name, " start busy"}, 32'(bus.busy), 32'd0);
        cycles = 0;
        done   = 1'b0;
        for (int c = 0; c < LAT_BOUND && !done; c++) begin
            applyStimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b1);
            if (!bus.busy) begin
                done = 1'b1;
            end else begin
                cycles++;
                checkOutput({v.name, " stall while busy"}, 32'(bus.stall_md), 32'd1);
                checkOutput({v.name, " hi hold"}, bus.hi, hi0);
                checkOutput({v.name, " lo hold"}, bus.lo, lo0);
            end
        end
        if (!done) noteTimeout(v.name);
        checkOutput({v.name, " busy cycles"}, 32'(cycles), 32'(v.lat));
        checkOutput({v.name, " stall after"}, 32'(bus.stall_md), 32'd0);
        checkOutput({v.name, " hi"}, bus.hi, v.exp_hi);
        checkOutput({v.name, " lo"}, bus.lo, v.exp_lo);
    endtask

    initial begin
        logic [31:0] hi_before;
        int          cycles;
        bit          done;

        tests_run    = 0;
        tests_failed = 0;

        // Vectors run back to back, so each one starts from the HI/LO that
        // the previous one left behind.
        vecs.push_back(mk("mult -3*7",     MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 5));
        vecs.push_back(mk("multu ff*2",    MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5));
        vecs.push_back(mk("div -7/2",      MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10));
        vecs.push_back(mk("divu 7/2",      MD_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 10));
        vecs.push_back(mk("div 7/-2",      MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10));
        vecs.push_back(mk("mult min*min",  MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5));
        vecs.push_back(mk("div min/-1",    MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10));
        vecs.push_back(mk("mtlo 1234",     MD_MTLO,  32'h00001234, 32'd0,        32'h00000000, 32'h00001234, 0));
        vecs.push_back(mk("mthi abcd",     MD_MTHI,  32'h0000ABCD, 32'd0,        32'h0000ABCD, 32'h00001234, 0));
        vecs.push_back(mk("mthi 5",        MD_MTHI,  32'd5,        32'd0,        32'h00000005, 32'h00001234, 0));
        vecs.push_back(mk("mtlo 5",        MD_MTLO,  32'd5,        32'd0,        32'h00000005, 32'h00000005, 0));
        vecs.push_back(mk("divu 7/0",      MD_DIVU,  32'd7,        32'd0,        32'h00000005, 32'h00000005, 10));
        vecs.push_back(mk("mthi 0",        MD_MTHI,  32'd0,        32'd0,        32'h00000000, 32'h00000005, 0));
        vecs.push_back(mk("mtlo ffff",     MD_MTLO,  32'hFFFFFFFF, 32'd0,        32'h00000000, 32'hFFFFFFFF, 0));
`ifdef MD_MADD_EN
        vecs.push_back(mk("maddu 1*1",     MD_MADDU, 32'd1,        32'd1,        32'h00000001, 32'h00000000, 5));
`else
        vecs.push_back(mk("maddu 1*1",     MD_MADDU, 32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 0));
`endif

        bus.start    = 1'b0;
        bus.op       = MD_MULT;
        bus.rs_e     = 32'd0;
        bus.rt_e     = 32'd0;
        bus.md_use_d = 1'b0;
        reset        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state.
        applyStimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b1);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset stall", 32'(bus.stall_md), 32'd0);
        checkOutput("reset hi", bus.hi, 32'd0);
        checkOutput("reset lo", bus.lo, 32'd0);

        foreach (vecs[i]) runVector(vecs[i]);

        // Start while busy: an MTHI and a DIV issued during a MULT must
        // neither write HI nor restart the counter. The MULT start cycle has
        // md_use_d low, so there is no stall yet.
        $display("[TB] sequence: start while busy");
        hi_before = bus.hi;
        applyStimulus(1'b1, MD_MULT, 32'd2, 32'd3, 1'b0);
        checkOutput("no use_d no stall", 32'(bus.stall_md), 32'd0);
        applyStimulus(1'b1, MD_MTHI, 32'h00000077, 32'd0, 1'b1);
        checkOutput("busy c1", 32'(bus.busy), 32'd1);
        checkOutput("stall c1", 32'(bus.stall_md), 32'd1);
        applyStimulus(1'b1, MD_DIV, 32'd100, 32'd10, 1'b1);
        checkOutput("mthi ignored", bus.hi, hi_before);
        cycles = 2;
        done   = 1'b0;
        for (int c = 0; c < LAT_BOUND && !done; c++) begin
            applyStimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b1);
            if (!bus.busy) done = 1'b1;
            else cycles++;
        end
        if (!done) noteTimeout("start while busy");
        checkOutput("no restart cycles", 32'(cycles), 32'd5);
        checkOutput("busy-start hi", bus.hi, 32'd0);
        checkOutput("busy-start lo", bus.lo, 32'd6);

        // Reset on the third busy cycle of a MULT aborts it.
        $display("[TB] sequence: reset mid-op");
        applyStimulus(1'b1, MD_MULT, 32'd5, 32'd5, 1'b0);
        applyStimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0);
        checkOutput("busy before reset", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        applyStimulus(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0);
        reset = 1'b0;
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        checkOutput("abort hi", bus.hi, 32'd0);
        checkOutput("abort lo", bus.lo, 32'd0);
        runVector(mk("multu 2*3 after reset", MD_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 5));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
